// File: rtl/wb_sram_pipe.sv
// wb_sram_pipe: pipelined Wishbone B4 slave around a behavioural SRAM.
// One request per clock, in-order ack/err, optional post-reset clear.
module wb_sram_pipe #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int READ_LATENCY = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] wb_adr,
    input  logic [DATA_WIDTH-1:0] wb_datwr,
    output logic [DATA_WIDTH-1:0] wb_datrd,
    input  logic                  wb_we,
    input  logic [SEL_WIDTH-1:0]  wb_sel,
    input  logic                  wb_stb,
    input  logic                  wb_cyc,
    output logic                  wb_stall,
    output logic                  wb_ack,
    output logic                  wb_err
);

    localparam int OFFB = $clog2(SEL_WIDTH);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    state_e state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic stall_q, stall_d;
    logic ack_q, ack_d;
    logic err_q, err_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] off;
    logic [ADDR_WIDTH-1:0] widx;
    logic [IW-1:0] idx;
    logic in_rng;
    logic acc;
    logic [DATA_WIDTH-1:0] rd_word;

    logic s0_ack, s0_err;
    logic [DATA_WIDTH-1:0] s0_dat;
    logic fin_ack, fin_err;
    logic [DATA_WIDTH-1:0] fin_dat;

    logic mem_we;
    logic [IW-1:0] mem_wi;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic [SEL_WIDTH-1:0] mem_wm;

    // Addresses below BASE_ADDR wrap to huge indices and fall out of range.
    always_comb begin
        off = wb_adr - BASE_ADDR;
        widx = off >> OFFB;
        in_rng = widx < ADDR_WIDTH'(DEPTH);
        idx = widx[IW-1:0];
        acc = wb_cyc & wb_stb & ~stall_q;
        rd_word = mem[idx];
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        unique case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = RUN;
                    cnt_d = '0;
                end
            end
            RUN: begin
                cnt_d = cnt_q;
            end
        endcase
        stall_d = (state_d == INIT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CLEAR_ON_RESET ? INIT : RUN;
            cnt_q <= '0;
            stall_q <= CLEAR_ON_RESET;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        mem_we = 1'b0;
        mem_wi = '0;
        mem_wd = '0;
        mem_wm = '0;
        if (state_q == INIT) begin
            mem_we = 1'b1;
            mem_wi = cnt_q;
            mem_wm = '1;
        end else if (acc && in_rng && wb_we) begin
            mem_we = 1'b1;
            mem_wi = idx;
            mem_wd = wb_datwr;
            mem_wm = wb_sel;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < SEL_WIDTH; i++) begin
                if (mem_wm[i]) begin
                    mem[mem_wi][8*i +: 8] <= mem_wd[8*i +: 8];
                end
            end
        end
    end

    // Stage 0: captured at the accept edge.
    always_comb begin
        s0_ack = acc & in_rng;
        s0_err = acc & ~in_rng;
        s0_dat = in_rng ? rd_word : '0;
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic p_ack_q, p_ack_d;
            logic p_err_q, p_err_d;
            logic [DATA_WIDTH-1:0] p_dat_q, p_dat_d;

            always_comb begin
                p_ack_d = s0_ack;
                p_err_d = s0_err;
                p_dat_d = s0_dat;
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    p_ack_q <= 1'b0;
                    p_err_q <= 1'b0;
                    p_dat_q <= '0;
                end else begin
                    p_ack_q <= p_ack_d;
                    p_err_q <= p_err_d;
                    p_dat_q <= p_dat_d;
                end
            end

            // Dropping wb_cyc kills whatever is still in flight.
            always_comb begin
                fin_ack = wb_cyc & p_ack_q;
                fin_err = wb_cyc & p_err_q;
                fin_dat = p_dat_q;
            end
        end else begin : g_lat1
            always_comb begin
                fin_ack = s0_ack;
                fin_err = s0_err;
                fin_dat = s0_dat;
            end
        end
    endgenerate

    always_comb begin
        ack_d = fin_ack;
        err_d = fin_err;
        dat_d = dat_q;
        if (fin_ack) begin
            dat_d = fin_dat;
        end else if (fin_err) begin
            dat_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= ack_d;
            err_q <= err_d;
            dat_q <= dat_d;
        end
    end

    assign wb_ack = ack_q;
    assign wb_err = err_q;
    assign wb_datrd = dat_q;
    assign wb_stall = stall_q;

endmodule

// File: tb/tb_wb_sram_pipe.sv
// Scoreboard bench for wb_sram_pipe: DEPTH=16, READ_LATENCY=2, clear on reset.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_wb_sram_pipe;

    localparam int DEPTH = 16;
    localparam int LAT = 2;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    logic [31:0] wb_adr = '0;
    logic [31:0] wb_datwr = '0;
    logic [31:0] wb_datrd;
    logic wb_we = 1'b0;
    logic [3:0] wb_sel = '0;
    logic wb_stb = 1'b0;
    logic wb_cyc = 1'b0;
    logic wb_stall;
    logic wb_ack;
    logic wb_err;

    typedef struct packed {
        logic err;
        logic chk;
        logic [31:0] dat;
    } exp_t;

    exp_t sb[$];
    int resp_log[$];
    int neg_cnt = 0;
    int ncomp = 0;
    int nfail = 0;
    int mark = 0;

    wb_sram_pipe #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .SEL_WIDTH(4),
        .DEPTH(DEPTH),
        .BASE_ADDR(BASE),
        .READ_LATENCY(LAT),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .wb_adr(wb_adr),
        .wb_datwr(wb_datwr),
        .wb_datrd(wb_datrd),
        .wb_we(wb_we),
        .wb_sel(wb_sel),
        .wb_stb(wb_stb),
        .wb_cyc(wb_cyc),
        .wb_stall(wb_stall),
        .wb_ack(wb_ack),
        .wb_err(wb_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        ncomp++;
        if (act !== want) begin
            nfail++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel,
                         input logic eerr, input logic echk,
                         input logic [31:0] edat, input logic push);
        exp_t e;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_we = we;
        wb_adr = adr;
        wb_datwr = dat;
        wb_sel = sel;
        e.err = eerr;
        e.chk = echk;
        e.dat = edat;
        if (push) sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] edat,
                      input logic [3:0] sel);
        issue(1'b0, adr, 32'h0, sel, 1'b0, 1'b1, edat, 1'b1);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel);
        issue(1'b1, adr, dat, sel, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic bad(input logic we, input logic [31:0] adr);
        issue(we, adr, 32'h0BAD_0BAD, 4'hF, 1'b1, 1'b1, 32'h0, 1'b1);
    endtask

    task automatic idle(input int n);
        wb_stb = 1'b0;
        wb_we = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_init(input string nm);
        int n;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clock);
            #1;
            n++;
            if (!wb_stall) break;
        end
        chk(nm, 32'(n), 32'(DEPTH));
    endtask

    task automatic chk_run(input string nm, input int n);
        chk({nm, "_cnt"}, 32'(resp_log.size()), 32'(n));
        chk({nm, "_first"},
            32'(resp_log.size() > 0 ? resp_log[0] : -1), 32'(mark + LAT));
        chk({nm, "_last"},
            32'(resp_log.size() > 0 ? resp_log[resp_log.size()-1] : -1),
            32'(mark + LAT + n - 1));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            neg_cnt++;
            if (wb_ack || wb_err) begin
                resp_log.push_back(neg_cnt);
                ncomp++;
                if (wb_ack && wb_err) begin
                    nfail++;
                    $display("FAIL ack_err_both: got ack=1 err=1 want one");
                end
                if (sb.size() == 0) begin
                    nfail++;
                    $display("FAIL unexpected_resp: got ack=%0b err=%0b want none",
                             wb_ack, wb_err);
                end else begin
                    e = sb.pop_front();
                    if (wb_err !== e.err) begin
                        nfail++;
                        $display("FAIL resp_kind: got err=%0b want err=%0b",
                                 wb_err, e.err);
                    end
                    if (e.chk) begin
                        ncomp++;
                        if (wb_datrd !== e.dat) begin
                            nfail++;
                            $display("FAIL resp_data: got %h want %h",
                                     wb_datrd, e.dat);
                        end
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [31:0] v;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ack", 32'(wb_ack), 32'h0);
        chk("rst_err", 32'(wb_err), 32'h0);
        chk("rst_datrd", wb_datrd, 32'h0);
        chk("rst_stall", 32'(wb_stall), 32'h1);
        reset_n = 1'b1;
        wait_init("init_len");

        rd(BASE + 32'h14, 32'h0, 4'hF);
        idle(4);

        resp_log.delete();
        wr(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
        mark = neg_cnt;
        wr(BASE + 32'h10, 32'h0000_00AA, 4'h1);
        rd(BASE + 32'h10, 32'hDEAD_BEAA, 4'hF);
        idle(5);
        chk_run("rmw_run", 3);
        chk("rmw_hold", wb_datrd, 32'hDEAD_BEAA);

        for (int i = 0; i < 8; i++) begin
            v = 32'h1111_1111 * 32'(i + 1);
            wr(BASE + 32'(4 * i), v, 4'hF);
        end
        idle(4);
        resp_log.delete();
        for (int i = 0; i < 8; i++) begin
            v = 32'h1111_1111 * 32'(i + 1);
            rd(BASE + 32'(4 * i), v, i[0] ? 4'h0 : 4'hF);
            if (i == 0) mark = neg_cnt;
        end
        idle(6);
        chk_run("burst_run", 8);

        bad(1'b1, BASE + 32'h40);
        bad(1'b1, BASE - 32'd4);
        rd(BASE + 32'h00, 32'h1111_1111, 4'hF);
        rd(BASE + 32'h3C, 32'h0, 4'hF);
        rd(BASE + 32'h1A, 32'h7777_7777, 4'hF);
        bad(1'b0, BASE + 32'h40);
        bad(1'b0, BASE - 32'd4);
        idle(5);
        chk("err_datrd", wb_datrd, 32'h0);

        wr(BASE + 32'h24, 32'hCAFE_F00D, 4'hF);
        idle(3);
        rd(BASE + 32'h00, 32'h1111_1111, 4'hF);
        rd(BASE + 32'h04, 32'h2222_2222, 4'hF);
        issue(1'b0, BASE + 32'h08, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0, 1'b0);
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        chk("abort_pending", 32'(sb.size()), 32'h0);
        rd(BASE + 32'h24, 32'hCAFE_F00D, 4'hF);
        idle(4);

        wr(BASE + 32'h14, 32'h55AA_55AA, 4'hF);
        rd(BASE + 32'h14, 32'h55AA_55AA, 4'hF);
        idle(4);
        rd(BASE + 32'h00, 32'h1111_1111, 4'hF);
        rd(BASE + 32'h04, 32'h2222_2222, 4'hF);
        rd(BASE + 32'h08, 32'h3333_3333, 4'hF);
        rd(BASE + 32'h0C, 32'h4444_4444, 4'hF);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(wb_ack), 32'h0);
        chk("mid_rst_err", 32'(wb_err), 32'h0);
        chk("mid_rst_datrd", wb_datrd, 32'h0);
        chk("mid_rst_stall", 32'(wb_stall), 32'h1);
        sb.delete();
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        wait_init("reinit_len");
        rd(BASE + 32'h14, 32'h0, 4'hF);
        idle(5);
        chk("final_pending", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
